data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Parametrised, byte-addressable data memory with a valid/ready request port, a one-cycle response strobe and configurable wait states. It sits behind the RISC-V core's MEM stage and replaces the word-only MemRead/MemWrite data memory. It adds RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW), alignment and range error reporting, and latency modelling for slower backing stores.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- WAIT_STATES, 0: extra cycles between request acceptance and response; 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned, out of range or illegal funct3).

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE
  - req_ready=1.
  - When req_valid is high, the request is accepted and we, funct3, addr and wdata are latched.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT
  - req_ready=0.
  - A down-counter is loaded with WAIT_STATES-1 on acceptance.
  - Exit to RESP when the counter reaches 0.
  - req_* inputs are ignored; only latched values are used.
- RESP
  - req_ready=0 and rsp_valid=1 for exactly one cycle.
  - A store commits on the clock edge that ends RESP.
  - Next state is IDLE.
- Word index = addr[31:2]; lane = addr[1:0].
- Error conditions, any of which sets rsp_err=1:
  - Word index >= DEPTH_WORDS.
  - funct3 in {011, 110, 111}, or funct3 in {100, 101} with we=1.
  - H/HU with lane[0]=1.
  - W with lane != 0.
- On error there is no memory write and rsp_rdata=0.
- Stores
  - SB writes byte lane `lane` with wdata[7:0].
  - SH writes lanes {lane[1],0} and {lane[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes keep their old value.
- Loads
  - B selects byte `lane` and sign-extends it; BU zero-extends it.
  - H selects halfword lane[1] and sign-extends it; HU zero-extends it.
  - W returns the whole word.
- Memory array contents are zero at time zero and are NOT cleared by rst_n, so the array maps to block RAM.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: if a request is accepted at edge N, rsp_valid is high during cycle N+WAIT_STATES+1.
- Throughput: one request per WAIT_STATES+2 cycles. req_ready rises again in the cycle after RESP.
- rsp_rdata and rsp_err are registered. They are valid only while rsp_valid=1 and are 0 in every other cycle.
- A load is read from the array in the WAIT→RESP or IDLE→RESP transition cycle. It therefore observes every store that committed earlier.
- Back-to-back ordering: a store followed immediately by a load to the same address returns the stored value.
- Reset mid-operation (WAIT or RESP, before the commit edge):
  - The pending request is dropped and its store is not committed.
  - No response is produced.
  - Outputs return to their reset values immediately, because reset is asynchronous.
- req_valid asserted while req_ready=0 is ignored. There is no queuing, so the requester must hold req_valid until req_ready=1.
- WAIT_STATES=0 gives a two-state FSM (IDLE↔RESP), and the counter logic is unused.

## Test plan
- Reset: assert rst_n=0 mid-stream -> req_ready=1 and rsp_valid=0, rsp_rdata=0, rsp_err=0 within the same cycle; a SW in WAIT when reset hits leaves the target word unchanged.
- SW 0x12345678 @0x10, then LW @0x10 -> rsp_rdata=0x12345678, rsp_err=0. LBU @0x11 -> 0x56. LH @0x12 -> 0x00001234.
- SB 0x80 @0x23 onto word 0 -> LW @0x20 = 0x80000000; LB @0x23 = 0xFFFFFF80; LBU @0x23 = 0x00000080. SH 0xBEEF @0x20 -> LW = 0x8000BEEF.
- Misaligned and illegal requests:
  - LW @0x02 -> rsp_err=1, rdata=0.
  - SH 0xFFFF @0x05 -> rsp_err=1, and a following LW @0x04 is unchanged.
  - funct3=011 -> rsp_err=1.
- Range: with DEPTH_WORDS=256, SW @0x400 -> rsp_err=1 and no write occurs (LW @0x000 unchanged); LW @0x3FC -> rsp_err=0.
- Wait states: with WAIT_STATES=3, a request accepted at edge N gives rsp_valid only in cycle N+4, req_ready=0 in cycles N+1..N+4, and a req_valid pulse during WAIT is ignored.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the MEM stage and the data memory LSU.
// The master issues valid/ready requests; the slave answers with a one-cycle strobe.
interface data_mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with RV32I sub-word loads/stores, error reporting
// and a configurable number of wait states between acceptance and response.
module data_mem_lsu #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   data_mem_lsu_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        lat_we_reg;
   logic [2:0]  lat_funct3_reg;
   logic [31:0] lat_addr_reg;
   logic [31:0] lat_wdata_reg;
   logic        rsp_valid_reg;
   logic        rsp_err_reg;

   logic        accept;
   logic        rd_en;
   logic        wr_en;
   logic        cur_we;
   logic [2:0]  cur_funct3;
   logic [31:0] cur_addr;
   logic        idx_oob, f3_bad, misal, cur_err;
   logic [AW-1:0] rd_idx, wr_idx;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] rd_word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // With no wait states the read and the error check happen on the accepting
   // edge, so they must look at the live request rather than the latched copy.
   assign cur_we     = (state_reg == IDLE) ? bus.req_we     : lat_we_reg;
   assign cur_funct3 = (state_reg == IDLE) ? bus.req_funct3 : lat_funct3_reg;
   assign cur_addr   = (state_reg == IDLE) ? bus.req_addr   : lat_addr_reg;

   assign idx_oob = |cur_addr[31:AW+2];
   assign misal   = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                    ((cur_funct3 == 3'b010) && (cur_addr[1:0] != 2'b00));
   always_comb begin
      f3_bad = 1'b0;
      case (cur_funct3)
         3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
         3'b100, 3'b101:         f3_bad = cur_we;
         default:                f3_bad = 1'b1;
      endcase
   end
   assign cur_err = idx_oob | f3_bad | misal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bus.req_ready = 1'b0;
      rd_en         = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (WAIT_STATES > 0) begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end else begin
                  state_next = RESP;
                  rd_en      = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
               rd_en      = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign accept = (state_reg == IDLE) && bus.req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we_reg     <= 1'b0;
         lat_funct3_reg <= 3'd0;
         lat_addr_reg   <= 32'd0;
         lat_wdata_reg  <= 32'd0;
         rsp_valid_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
      end else begin
         if (accept) begin
            lat_we_reg     <= bus.req_we;
            lat_funct3_reg <= bus.req_funct3;
            lat_addr_reg   <= bus.req_addr;
            lat_wdata_reg  <= bus.req_wdata;
         end
         rsp_valid_reg <= rd_en;
         rsp_err_reg   <= rd_en & cur_err;
      end
   end

   // Store commits on the edge that ends RESP; a reset before then drops it.
   assign wr_en  = (state_reg == RESP) && lat_we_reg && !rsp_err_reg;
   assign wr_idx = lat_addr_reg[AW+1:2];
   assign rd_idx = cur_addr[AW+1:2];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = lat_wdata_reg;
      case (lat_funct3_reg[1:0])
         2'b00: begin
            be        = 4'b0001 << lat_addr_reg[1:0];
            wdata_rep = {4{lat_wdata_reg[7:0]}};
         end
         2'b01: begin
            be        = lat_addr_reg[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{lat_wdata_reg[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   // One byte-wide RAM per lane; contents power up as zero and survive reset.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] rd_byte_reg;
         always_ff @(posedge clk) begin
            if (wr_en && be[gi])
               mem[wr_idx] <= wdata_rep[gi*8 +: 8];
            if (rd_en)
               rd_byte_reg <= mem[rd_idx];
         end
         assign rd_word[gi*8 +: 8] = rd_byte_reg;
      end
   endgenerate

   always_comb begin
      case (lat_addr_reg[1:0])
         2'b00:   byte_sel = rd_word[7:0];
         2'b01:   byte_sel = rd_word[15:8];
         2'b10:   byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = lat_addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
      case (lat_funct3_reg)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = rd_word;
      endcase
   end

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.rsp_rdata = (rsp_valid_reg && !rsp_err_reg && !lat_we_reg) ? load_ext : 32'd0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench: two LSUs (0 and 3 wait states) against a byte-array model,
// plus literal expectations per directed vector.
module tb_data_mem_lsu;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        vld [2];
   logic        wen [2];
   logic [2:0]  f3s [2];
   logic [31:0] adr [2];
   logic [31:0] wds [2];
   logic        rdy [2];
   logic        rv  [2];
   logic        rerr[2];
   logic [31:0] rdat[2];

   data_mem_lsu_if bus0 ();
   data_mem_lsu_if bus1 ();

   assign bus0.req_valid  = vld[0];
   assign bus0.req_we     = wen[0];
   assign bus0.req_funct3 = f3s[0];
   assign bus0.req_addr   = adr[0];
   assign bus0.req_wdata  = wds[0];
   assign rdy[0]  = bus0.req_ready;
   assign rv[0]   = bus0.rsp_valid;
   assign rerr[0] = bus0.rsp_err;
   assign rdat[0] = bus0.rsp_rdata;

   assign bus1.req_valid  = vld[1];
   assign bus1.req_we     = wen[1];
   assign bus1.req_funct3 = f3s[1];
   assign bus1.req_addr   = adr[1];
   assign bus1.req_wdata  = wds[1];
   assign rdy[1]  = bus1.req_ready;
   assign rv[1]   = bus1.rsp_valid;
   assign rerr[1] = bus1.rsp_err;
   assign rdat[1] = bus1.rsp_rdata;

   data_mem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   data_mem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          d;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          acc;
   } req_t;
   req_t q[$];

   logic [7:0]  mm [2][1024];
   logic [31:0] last_rd  [2];
   logic        last_err [2];
   int          last_rsp [2];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %08h required %08h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   // Reference behaviour: memory as a flat byte array, sizes and alignment by arithmetic.
   function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic err, output logic [31:0] rd);
      int sz;
      logic sgn;
      logic [31:0] v;
      err = 1'b0; rd = 32'd0; sz = 1; sgn = 1'b0;
      case (f3)
         3'b000: begin sz = 1; sgn = 1'b1; end
         3'b001: begin sz = 2; sgn = 1'b1; end
         3'b010: begin sz = 4; sgn = 1'b0; end
         3'b100: begin sz = 1; sgn = 1'b0; err = we; end
         3'b101: begin sz = 2; sgn = 1'b0; err = we; end
         default: err = 1'b1;
      endcase
      if (a >= 32'd1024) err = 1'b1;
      if ((a % sz) != 0) err = 1'b1;
      if (err) return;
      if (we) begin
         for (int i = 0; i < sz; i++) mm[d][a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < sz; i++) v = v | (32'(mm[d][a + i]) << (8*i));
         if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
         rd = v;
      end
   endfunction

   initial begin
      foreach (mm[i, j]) mm[i][j] = 8'h00;
      for (int d = 0; d < 2; d++) begin
         last_rd[d] = 32'd0; last_err[d] = 1'b0; last_rsp[d] = -10;
      end
   end

   always @(negedge clk) begin
      req_t r;
      logic e_err;
      logic [31:0] e_rd;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            chk($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("rst_valid%0d", d), {30'd0, rv[d], rerr[d]}, 32'd0);
            chk($sformatf("rst_rdata%0d", d), rdat[d], 32'd0);
         end else if (rv[d]) begin
            if (q.size() == 0 || q[0].d != d) begin
               fail_now($sformatf("spurious_rsp dut%0d cyc %0d", d, cyc));
            end else begin
               r = q.pop_front();
               model(d, r.we, r.f3, r.a, r.wd, e_err, e_rd);
               chk($sformatf("rdata%0d@%08h", d, r.a), rdat[d], e_rd);
               chk($sformatf("err%0d@%08h", d, r.a), 32'(rerr[d]), 32'(e_err));
               chk($sformatf("latency%0d", d), cyc, r.acc + ws_of(d) + 1);
               chk($sformatf("resp_ready%0d", d), 32'(rdy[d]), 32'd0);
               $display("dut%0d cyc %0d %s f3=%b addr=%08h wdata=%08h -> rdata=%08h err=%b",
                        d, cyc, r.we ? "ST" : "LD", r.f3, r.a, r.wd, rdat[d], rerr[d]);
               last_rd[d]  = rdat[d];
               last_err[d] = rerr[d];
               last_rsp[d] = cyc;
            end
         end else begin
            chk($sformatf("idle_rdata%0d", d), rdat[d], 32'd0);
            chk($sformatf("idle_err%0d", d), 32'(rerr[d]), 32'd0);
            if (q.size() > 0 && q[0].d == d && cyc > q[0].acc)
               chk($sformatf("busy_ready%0d", d), 32'(rdy[d]), 32'd0);
            if (cyc == last_rsp[d] + 1)
               chk($sformatf("ready_back%0d", d), 32'(rdy[d]), 32'd1);
         end
      end
   end

   task automatic start(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      int t = 0;
      @(negedge clk);
      while (!rdy[d] && t < 50) begin @(negedge clk); t++; end
      if (!rdy[d]) begin
         fail_now($sformatf("ready_timeout dut%0d", d));
         return;
      end
      vld[d] = 1'b1; wen[d] = we; f3s[d] = f3; adr[d] = a; wds[d] = wd;
      q.push_back('{d, we, f3, a, wd, cyc});
      @(posedge clk);
      #1 vld[d] = 1'b0;
   endtask

   task automatic finish(input int d);
      int t = 0;
      while (q.size() != 0 && t < 50) begin @(negedge clk); #1; t++; end
      if (q.size() != 0) begin
         fail_now($sformatf("rsp_timeout dut%0d", d));
         q.delete();
      end
   endtask

   task automatic txn(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      start(d, we, f3, a, wd);
      finish(d);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   vec_t v0 [33] = '{
      '{1'b1, 3'b010, 32'h020, 32'h0000_0000, 1'b0, 32'h0000_0000},
      '{1'b1, 3'b010, 32'h004, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000},
      '{1'b1, 3'b010, 32'h000, 32'hCAFE_F00D, 1'b0, 32'h0000_0000},
      '{1'b1, 3'b010, 32'h3FC, 32'h0BAD_C0DE, 1'b0, 32'h0000_0000},
      '{1'b1, 3'b010, 32'h010, 32'h1234_5678, 1'b0, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h010, 32'h0000_0000, 1'b0, 32'h1234_5678},
      '{1'b0, 3'b100, 32'h011, 32'h0000_0000, 1'b0, 32'h0000_0056},
      '{1'b0, 3'b001, 32'h012, 32'h0000_0000, 1'b0, 32'h0000_1234},
      '{1'b1, 3'b000, 32'h023, 32'h0000_0080, 1'b0, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h020, 32'h0000_0000, 1'b0, 32'h8000_0000},
      '{1'b0, 3'b000, 32'h023, 32'h0000_0000, 1'b0, 32'hFFFF_FF80},
      '{1'b0, 3'b100, 32'h023, 32'h0000_0000, 1'b0, 32'h0000_0080},
      '{1'b1, 3'b001, 32'h020, 32'h0000_BEEF, 1'b0, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h020, 32'h0000_0000, 1'b0, 32'h8000_BEEF},
      '{1'b0, 3'b001, 32'h022, 32'h0000_0000, 1'b0, 32'hFFFF_8000},
      '{1'b0, 3'b101, 32'h020, 32'h0000_0000, 1'b0, 32'h0000_BEEF},
      '{1'b0, 3'b001, 32'h020, 32'h0000_0000, 1'b0, 32'hFFFF_BEEF},
      '{1'b0, 3'b010, 32'h002, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'b001, 32'h005, 32'h0000_FFFF, 1'b1, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h004, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5},
      '{1'b0, 3'b011, 32'h000, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'b100, 32'h000, 32'h0000_00FF, 1'b1, 32'h0000_0000},
      '{1'b0, 3'b110, 32'h010, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D},
      '{1'b0, 3'b010, 32'h3FC, 32'h0000_0000, 1'b0, 32'h0BAD_C0DE},
      '{1'b0, 3'b010, 32'h400, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'b001, 32'h013, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'b000, 32'h012, 32'hABCD_EF11, 1'b0, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h010, 32'h0000_0000, 1'b0, 32'h1211_5678},
      '{1'b1, 3'b001, 32'h012, 32'h1234_ABCD, 1'b0, 32'h0000_0000},
      '{1'b0, 3'b010, 32'h010, 32'h0000_0000, 1'b0, 32'hABCD_5678},
      '{1'b0, 3'b000, 32'h011, 32'h0000_0000, 1'b0, 32'h0000_0056}
   };

   initial begin
      for (int d = 0; d < 2; d++) begin
         vld[d] = 1'b0; wen[d] = 1'b0; f3s[d] = 3'd0; adr[d] = 32'd0; wds[d] = 32'd0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 33; i++) begin
         txn(0, v0[i].we, v0[i].f3, v0[i].a, v0[i].wd);
         chk($sformatf("pin%0d_rdata", i), last_rd[0], v0[i].rd);
         chk($sformatf("pin%0d_err", i), 32'(last_err[0]), 32'(v0[i].err));
      end

      // Three wait states: setup stores, then a sub-word load.
      txn(1, 1'b1, 3'b010, 32'h40, 32'h1111_1111);
      txn(1, 1'b1, 3'b010, 32'h44, 32'h2222_2222);
      txn(1, 1'b0, 3'b100, 32'h43, 32'h0);
      chk("ws_lbu43", last_rd[1], 32'h0000_0011);

      // A request offered while the block is busy must be ignored.
      start(1, 1'b1, 3'b010, 32'h48, 32'h3333_3333);
      @(negedge clk);
      vld[1] = 1'b1; wen[1] = 1'b1; f3s[1] = 3'b010; adr[1] = 32'h44; wds[1] = 32'h9999_9999;
      @(negedge clk);
      vld[1] = 1'b0;
      finish(1);
      txn(1, 1'b0, 3'b010, 32'h44, 32'h0);
      chk("ws_ignored_store", last_rd[1], 32'h2222_2222);
      txn(1, 1'b0, 3'b010, 32'h48, 32'h0);
      chk("ws_lw48", last_rd[1], 32'h3333_3333);

      // Reset lands while a store sits in WAIT: it must never commit.
      start(1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
      @(negedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("async_rst_ready", 32'(rdy[1]), 32'd1);
      chk("async_rst_valid", 32'(rv[1]), 32'd0);
      chk("async_rst_err", 32'(rerr[1]), 32'd0);
      chk("async_rst_rdata", rdat[1], 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      txn(1, 1'b0, 3'b010, 32'h40, 32'h0);
      chk("rst_dropped_store", last_rd[1], 32'h1111_1111);
      txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
      chk("mem_kept_over_rst", last_rd[0], 32'hABCD_5678);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
